// File: rtl/sb_dest_router.sv
// Switchboard-stream demultiplexer: steers each packet to one of N ports by a dest field,
// locking the route for the whole packet and draining/counting packets to nonexistent ports.
module sb_dest_router #(
  parameter int DW      = 416,
  parameter int N       = 4,
  parameter int SEL_LSB = 0,
  parameter int SELW    = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [DW-1:0] in_data,
  input  logic [31:0]   in_dest,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic [31:0]   out_dest,
  output logic          out_last,
  output logic [N-1:0]  out_valid,
  input  logic [N-1:0]  out_ready,
  output logic [15:0]   drop_count
);

  typedef enum logic [1:0] {ST_FIRST, ST_LOCKED, ST_DROPPING} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [DW-1:0]   r_data;
  logic [31:0]     r_dest;
  logic            r_last;
  logic [N-1:0]    r_valid;
  logic [SELW-1:0] r_route;
  logic [15:0]     r_dropCount;

  logic [SELW-1:0] w_sel;
  logic            w_selOk;
  logic            w_drain;
  logic            w_bufFree;
  logic            w_load;
  logic            w_dropDone;
  logic [SELW-1:0] w_loadRoute;
  logic [N-1:0]    w_onehot;

  assign w_sel     = in_dest[SEL_LSB +: SELW];
  assign w_selOk   = ({1'b0, w_sel} < (SELW+1)'(N));
  // r_valid is one-hot, so this is out_ready of the buffered beat's port.
  assign w_drain   = |(r_valid & out_ready);
  assign w_bufFree = ~(|r_valid) | w_drain;

  assign w_loadRoute = (r_state == ST_FIRST) ? w_sel : r_route;

  always_comb begin
    w_onehot = '0;
    for (int k = 0; k < N; k++) begin
      w_onehot[k] = (w_loadRoute == SELW'(k));
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_FIRST;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_FIRST: begin
        if (in_valid && in_ready && !in_last) begin
          w_nextState = w_selOk ? ST_LOCKED : ST_DROPPING;
        end
      end
      ST_LOCKED, ST_DROPPING: begin
        if (in_valid && in_ready && in_last) begin
          w_nextState = ST_FIRST;
        end
      end
      default: w_nextState = ST_FIRST;
    endcase
  end

  // Drop-destined first beats are always taken so a stalled port never blocks draining.
  always_comb begin
    in_ready   = 1'b0;
    w_load     = 1'b0;
    w_dropDone = 1'b0;
    case (r_state)
      ST_FIRST: begin
        in_ready   = w_selOk ? w_bufFree : 1'b1;
        w_load     = in_valid & w_selOk & w_bufFree;
        w_dropDone = in_valid & ~w_selOk & in_last;
      end
      ST_LOCKED: begin
        in_ready = w_bufFree;
        w_load   = in_valid & w_bufFree;
      end
      ST_DROPPING: begin
        in_ready   = 1'b1;
        w_dropDone = in_valid & in_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_data      <= '0;
      r_dest      <= '0;
      r_last      <= 1'b0;
      r_valid     <= '0;
      r_route     <= '0;
      r_dropCount <= '0;
    end else begin
      if (w_load) begin
        r_data  <= in_data;
        r_last  <= in_last;
        r_valid <= w_onehot;
        if (r_state == ST_FIRST) begin
          r_dest  <= in_dest;
          r_route <= w_sel;
        end
      end else if (w_drain) begin
        r_valid <= '0;
      end
      if (w_dropDone && (r_dropCount != 16'hFFFF)) begin
        r_dropCount <= r_dropCount + 16'd1;
      end
    end
  end

  assign out_data   = r_data;
  assign out_dest   = r_dest;
  assign out_last   = r_last;
  assign out_valid  = r_valid;
  assign drop_count = r_dropCount;

endmodule
